// File: rtl/hex_to_7seg_decoder.sv
// hex_to_7seg_decoder: registered hex nibble to seven-segment drive word.
// Optional Blank input when HEX7SEG_BLANK_EN is defined.
module hex_to_7seg_decoder #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Hex,
   input  logic       DP,
`ifdef HEX7SEG_BLANK_EN
   input  logic       Blank,
`endif
   output logic [7:0] SSeg
);

   localparam logic [7:0] DARK = {8{ACTIVE_LOW}};

   logic [6:0] glyph;
   logic [7:0] lit;
   logic [7:0] drive;

   // Nibble to lit-high glyph (bit0=a .. bit6=g); X on Hex stays X
   always_comb begin
      glyph = 'x;
      unique case (Hex)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
      endcase
   end

   // Add DP, apply blanking, then map lit-high to pin polarity
   always_comb begin
      lit = {DP, glyph};
`ifdef HEX7SEG_BLANK_EN
      if (Blank)
         lit = 8'h00;
`endif
      drive = lit ^ DARK;
   end

   // Output register keeps pins glitch-free; dark while in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         SSeg <= DARK;
      else
         SSeg <= drive;
   end

endmodule

// File: tb/tb_hex_to_7seg_decoder.sv
// tb_hex_to_7seg_decoder: directed scoreboard bench for both polarities.
// Expected words come from the active-low code table below.
module tb_hex_to_7seg_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] Hex = 4'h0;
   logic       DP = 1'b0;
   logic       Blank = 1'b0;
   logic [7:0] SSeg;
   logic [7:0] SSeg0;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   logic [7:0] last;

   localparam logic [6:0] TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   always #5 clk = ~clk;

   hex_to_7seg_decoder #(.ACTIVE_LOW(1'b1)) dut (
      .clk  (clk),
      .rst  (rst),
      .Hex  (Hex),
      .DP   (DP),
`ifdef HEX7SEG_BLANK_EN
      .Blank(Blank),
`endif
      .SSeg (SSeg)
   );

   hex_to_7seg_decoder #(.ACTIVE_LOW(1'b0)) dut0 (
      .clk  (clk),
      .rst  (rst),
      .Hex  (Hex),
      .DP   (DP),
`ifdef HEX7SEG_BLANK_EN
      .Blank(Blank),
`endif
      .SSeg (SSeg0)
   );

   // Active-low expectation for one input set
   function automatic logic [7:0] model(input logic [3:0] h,
                                        input logic d,
                                        input logic b);
      logic [7:0] w;
      w = {~d, TBL[h]};
`ifdef HEX7SEG_BLANK_EN
      if (b)
         w = 8'hFF;
`else
      if (b)
         w = {~d, TBL[h]};
`endif
      return w;
   endfunction

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Pop one expectation and compare both polarities
   task automatic score(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got empty scoreboard, expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, SSeg, e);
         check({tag, "_al0"}, SSeg0, ~e);
         last = e;
      end
   endtask

   // Drive at negedge, confirm no early change, then score after edge
   task automatic step(input string tag, input logic [3:0] h,
                       input logic d, input logic b);
      @(negedge clk);
      Hex = h;
      DP = d;
      Blank = b;
      exp_q.push_back(model(h, d, b));
      #1;
      check({tag, "_hold"}, SSeg, last);
      @(posedge clk);
      #1;
      score(tag);
   endtask

   initial begin
      last = 8'hFF;
      Hex = 4'h8;
      DP = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_al1", SSeg, 8'hFF);
      check("rst_al0", SSeg0, 8'h00);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_hold", SSeg, 8'hFF);
      exp_q.push_back(model(4'h8, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      score("rel_cap");

      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_al1", SSeg, 8'hFF);
      check("async_al0", SSeg0, 8'h00);
      @(posedge clk);
      #1;
      check("rst_held", SSeg, 8'hFF);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rel2", SSeg, 8'hFF);
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      score("rst_cap2");

      for (int i = 0; i < 16; i++)
         step($sformatf("dp0_%0h", i), 4'(i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         step($sformatf("dp1_%0h", i), 4'(i), 1'b1, 1'b0);

      step("lat_3", 4'h3, 1'b0, 1'b0);
      check("lat_b0", SSeg, 8'hB0);
      step("lat_e", 4'hE, 1'b0, 1'b0);
      check("lat_86", SSeg, 8'h86);

      step("pol_1", 4'h1, 1'b1, 1'b0);
      check("pol_al0", SSeg0, 8'h86);

      step("blank_on", 4'h8, 1'b1, 1'b1);
      step("blank_off", 4'h8, 1'b1, 1'b0);
      step("blank_dp0", 4'hA, 1'b0, 1'b1);

      for (int i = 0; i < 20; i++)
         step("rand", 4'($urandom_range(15)),
              1'($urandom_range(1)), 1'($urandom_range(1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
